lagarto_l15_req_arbiter: RTL and testbench



---
 rtl/lagarto_l15_req_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_lagarto_l15_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_l15_req_arbiter.sv
// ============================================================================
// Module   : lagarto_l15_req_arbiter
// Brief    : Arbitrates the L1.5 request channel between the icache and dcache
//            requesters, routes returns by thread-id tag, and tracks outstanding
//            requests per requester.
// Option   : L15_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lagarto_l15_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4,
    parameter int TID_W     = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [NUM_REQ-1:0]        req_val_i,
    input  logic [NUM_REQ*5-1:0]      req_rqtype_i,
    input  logic [NUM_REQ*3-1:0]      req_size_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic                      l15_val_o,
    output logic [4:0]                l15_rqtype_o,
    output logic [2:0]                l15_size_o,
    output logic [ADDR_W-1:0]         l15_addr_o,
    output logic [DATA_W-1:0]         l15_data_o,
    output logic [TID_W-1:0]          l15_threadid_o,
    input  logic                      l15_ack_i,
    input  logic                      l15_rtrn_val_i,
    input  logic [TID_W-1:0]          l15_rtrn_threadid_i,
    input  logic [DATA_W-1:0]         l15_rtrn_data_i,
    output logic [NUM_REQ-1:0]        rtrn_val_o,
    output logic [DATA_W-1:0]         rtrn_data_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int CNT_W = 4;
    localparam int SLOTS = 2**TID_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e             state_q;
    logic [4:0]         rqtype_q;
    logic [2:0]         size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [TID_W-1:0]   grant_q;
    logic               err_q;
`ifndef L15_ARB_FIXED_PRIO_EN
    logic [TID_W-1:0]   rr_ptr_q;
`endif

    // Per-slot views padded to 2**TID_W so a TID_W-wide index never goes out of range.
    logic [SLOTS-1:0]   w_elig;
    logic [4:0]         w_rqtype [SLOTS];
    logic [2:0]         w_size   [SLOTS];
    logic [ADDR_W-1:0]  w_addr   [SLOTS];
    logic [DATA_W-1:0]  w_data   [SLOTS];

    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;
    logic [NUM_REQ-1:0] w_underflow;
    logic [NUM_REQ-1:0] w_nz;
    logic               w_ack_fire;
    logic               w_bad_tag;
    logic               w_found;
    logic [TID_W-1:0]   w_win;
    logic [TID_W-1:0]   w_idx;

    assign w_ack_fire = (state_q == ST_REQ) && l15_ack_i;
    assign w_bad_tag  = l15_rtrn_val_i &&
                        ({1'b0, l15_rtrn_threadid_i} >= (TID_W+1)'(NUM_REQ));

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < NUM_REQ) begin : g_live
            localparam logic [TID_W-1:0] K = TID_W'(k);
            logic [CNT_W-1:0] cnt_q;

            assign w_rqtype[k]    = req_rqtype_i[k*5 +: 5];
            assign w_size[k]      = req_size_i[k*3 +: 3];
            assign w_addr[k]      = req_addr_i[k*ADDR_W +: ADDR_W];
            assign w_data[k]      = req_data_i[k*DATA_W +: DATA_W];
            assign w_elig[k]      = req_val_i[k] && (cnt_q < CNT_W'(MAX_OUTST));

            assign w_inc[k]       = w_ack_fire && (grant_q == K);
            assign w_dec[k]       = l15_rtrn_val_i && (l15_rtrn_threadid_i == K);
            assign w_underflow[k] = w_dec[k] && !w_inc[k] && (cnt_q == '0);
            assign w_nz[k]        = (cnt_q != '0);
            assign req_ack_o[k]   = w_inc[k];
            assign rtrn_val_o[k]  = rstn_i && w_dec[k];

            // Simultaneous ack and return for this requester cancel out.
            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    cnt_q <= '0;
                end else if (w_inc[k] && !w_dec[k]) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (w_dec[k] && !w_inc[k] && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end else begin : g_pad
            assign w_rqtype[k] = '0;
            assign w_size[k]   = '0;
            assign w_addr[k]   = '0;
            assign w_data[k]   = '0;
            assign w_elig[k]   = 1'b0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
`ifdef L15_ARB_FIXED_PRIO_EN
            w_idx = TID_W'(off);
`else
            w_idx = TID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
`endif
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            rqtype_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            grant_q  <= '0;
`ifndef L15_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        state_q  <= ST_REQ;
                        rqtype_q <= w_rqtype[w_win];
                        size_q   <= w_size[w_win];
                        addr_q   <= w_addr[w_win];
                        data_q   <= w_data[w_win];
                        grant_q  <= w_win;
`ifndef L15_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= (w_win == TID_W'(NUM_REQ-1)) ? '0 : w_win + TID_W'(1);
`endif
                    end
                end
                ST_REQ: begin
                    if (l15_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            err_q <= 1'b0;
        end else if (w_bad_tag || (|w_underflow)) begin
            err_q <= 1'b1;
        end
    end

    assign l15_val_o      = (state_q == ST_REQ);
    assign l15_rqtype_o   = rqtype_q;
    assign l15_size_o     = size_q;
    assign l15_addr_o     = addr_q;
    assign l15_data_o     = data_q;
    assign l15_threadid_o = grant_q;
    assign rtrn_data_o    = l15_rtrn_data_i;
    assign busy_o         = (state_q == ST_REQ) || (|w_nz);
    assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lagarto_l15_req_arbiter.sv
// ============================================================================
// Module   : tb_lagarto_l15_req_arbiter
// Brief    : Self-checking bench: directed vector table, hand sequences for the
//            outstanding limit, and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lagarto_l15_req_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int ADDR_W    = 40;
    localparam int DATA_W    = 64;
    localparam int MAX_OUTST = 4;
    localparam int TID_W     = 2;
    localparam int NVEC      = 24;

    logic                      clk_i = 1'b0;
    logic                      rstn_i;
    logic [NUM_REQ-1:0]        req_val_i;
    logic [NUM_REQ*5-1:0]      req_rqtype_i;
    logic [NUM_REQ*3-1:0]      req_size_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ack_o;
    logic                      l15_val_o;
    logic [4:0]                l15_rqtype_o;
    logic [2:0]                l15_size_o;
    logic [ADDR_W-1:0]         l15_addr_o;
    logic [DATA_W-1:0]         l15_data_o;
    logic [TID_W-1:0]          l15_threadid_o;
    logic                      l15_ack_i;
    logic                      l15_rtrn_val_i;
    logic [TID_W-1:0]          l15_rtrn_threadid_i;
    logic [DATA_W-1:0]         l15_rtrn_data_i;
    logic [NUM_REQ-1:0]        rtrn_val_o;
    logic [DATA_W-1:0]         rtrn_data_o;
    logic                      busy_o;
    logic                      err_o;

    always #5 clk_i = ~clk_i;

    lagarto_l15_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_OUTST(MAX_OUTST), .TID_W(TID_W)
    ) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i), .req_size_i(req_size_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_ack_o(req_ack_o),
        .l15_val_o(l15_val_o), .l15_rqtype_o(l15_rqtype_o), .l15_size_o(l15_size_o),
        .l15_addr_o(l15_addr_o), .l15_data_o(l15_data_o), .l15_threadid_o(l15_threadid_o),
        .l15_ack_i(l15_ack_i), .l15_rtrn_val_i(l15_rtrn_val_i),
        .l15_rtrn_threadid_i(l15_rtrn_threadid_i), .l15_rtrn_data_i(l15_rtrn_data_i),
        .rtrn_val_o(rtrn_val_o), .rtrn_data_o(rtrn_data_o), .busy_o(busy_o), .err_o(err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: transaction-level view of the arbiter.
    bit                m_req;
    int                m_g;
    int                m_rr;
    bit                m_err;
    int                m_cnt [NUM_REQ];
    logic [4:0]        m_rqtype;
    logic [2:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    typedef struct {
        logic       rstn;
        logic [1:0] val;
        logic       ack;
        logic       rv;
        logic [1:0] tid;
        logic       e_val;
        logic [1:0] e_tid;
        logic [1:0] e_ack;
        logic [1:0] e_rtrn;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_g = 0; m_rr = 0; m_err = 1'b0;
        m_rqtype = '0; m_size = '0; m_addr = '0; m_data = '0;
        for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = 0;
    endtask

    task automatic check_model();
        logic [NUM_REQ-1:0] e_ack;
        logic [NUM_REQ-1:0] e_rtrn;
        bit                 e_busy;
        e_ack  = (m_req && l15_ack_i) ? (NUM_REQ'(1) << m_g) : '0;
        e_rtrn = (rstn_i && l15_rtrn_val_i && int'(l15_rtrn_threadid_i) < NUM_REQ)
                 ? (NUM_REQ'(1) << l15_rtrn_threadid_i) : '0;
        e_busy = m_req;
        for (int k = 0; k < NUM_REQ; k++) if (m_cnt[k] != 0) e_busy = 1'b1;
        chk("m_l15_val",   128'(l15_val_o),      128'(m_req));
        chk("m_threadid",  128'(l15_threadid_o), 128'(m_g));
        chk("m_rqtype",    128'(l15_rqtype_o),   128'(m_rqtype));
        chk("m_size",      128'(l15_size_o),     128'(m_size));
        chk("m_addr",      128'(l15_addr_o),     128'(m_addr));
        chk("m_data",      128'(l15_data_o),     128'(m_data));
        chk("m_req_ack",   128'(req_ack_o),      128'(e_ack));
        chk("m_rtrn_val",  128'(rtrn_val_o),     128'(e_rtrn));
        chk("m_rtrn_data", 128'(rtrn_data_o),    128'(l15_rtrn_data_i));
        chk("m_busy",      128'(busy_o),         128'(e_busy));
        chk("m_err",       128'(err_o),          128'(m_err));
    endtask

    task automatic model_step();
        int w;
        int d;
        if (!rstn_i) begin
            model_reset();
            return;
        end
        w = -1;
        if (!m_req) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                int i;
                i = (m_rr + off) % NUM_REQ;
                if (w < 0 && bit'(req_val_i >> i) && m_cnt[i] < MAX_OUTST) w = i;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            d = 0;
            if (m_req && l15_ack_i && m_g == k) d++;
            if (l15_rtrn_val_i && int'(l15_rtrn_threadid_i) == k) d--;
            if (d > 0) m_cnt[k]++;
            else if (d < 0) begin
                if (m_cnt[k] == 0) m_err = 1'b1;
                else m_cnt[k]--;
            end
        end
        if (l15_rtrn_val_i && int'(l15_rtrn_threadid_i) >= NUM_REQ) m_err = 1'b1;
        if (m_req) begin
            if (l15_ack_i) m_req = 1'b0;
        end else if (w >= 0) begin
            m_req    = 1'b1;
            m_g      = w;
            m_rqtype = 5'(req_rqtype_i >> (5*w));
            m_size   = 3'(req_size_i >> (3*w));
            m_addr   = ADDR_W'(req_addr_i >> (ADDR_W*w));
            m_data   = DATA_W'(req_data_i >> (DATA_W*w));
            m_rr     = (w + 1) % NUM_REQ;
        end
    endtask

    task automatic sample();
        #3;
    endtask

    task automatic advance();
        check_model();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic rstn, input logic [1:0] val, input logic ack,
                                input logic rv, input logic [1:0] tid, input logic e_val,
                                input logic [1:0] e_tid, input logic [1:0] e_ack,
                                input logic [1:0] e_rtrn, input logic e_busy, input logic e_err);
        vec_t v;
        v.rstn = rstn; v.val = val; v.ack = ack; v.rv = rv; v.tid = tid;
        v.e_val = e_val; v.e_tid = e_tid; v.e_ack = e_ack; v.e_rtrn = e_rtrn;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    localparam logic [ADDR_W-1:0] ADDR0 = 40'h00_8000_0000;
    localparam logic [ADDR_W-1:0] ADDR1 = 40'h00_C000_1000;

    int ack1_cnt;
    int tsel;

    initial begin
        rstn_i = 1'b0; req_val_i = '0; l15_ack_i = 1'b0;
        l15_rtrn_val_i = 1'b0; l15_rtrn_threadid_i = '0;
        req_rqtype_i = {5'h02, 5'h01};
        req_size_i   = {3'd3, 3'd2};
        req_addr_i   = {ADDR1, ADDR0};
        req_data_i   = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        l15_rtrn_data_i = 64'hDEAD_BEEF_CAFE_F00D;

        //            rstn val  ack rv tid | val tid  ack   rtrn  busy err
        tbl[0]  = mk(1, 2'b01, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 0, 0);
        tbl[1]  = mk(1, 2'b01, 0, 0, 2'd0,  1, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[2]  = mk(1, 2'b01, 0, 0, 2'd0,  1, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[3]  = mk(1, 2'b01, 1, 0, 2'd0,  1, 2'd0, 2'b01, 2'b00, 1, 0);
        tbl[4]  = mk(1, 2'b00, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[5]  = mk(1, 2'b11, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[6]  = mk(1, 2'b11, 1, 0, 2'd0,  1, 2'd1, 2'b10, 2'b00, 1, 0);
        tbl[7]  = mk(1, 2'b11, 0, 0, 2'd0,  0, 2'd1, 2'b00, 2'b00, 1, 0);
        tbl[8]  = mk(1, 2'b11, 1, 0, 2'd0,  1, 2'd0, 2'b01, 2'b00, 1, 0);
        tbl[9]  = mk(1, 2'b11, 1, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[10] = mk(1, 2'b11, 1, 0, 2'd0,  1, 2'd1, 2'b10, 2'b00, 1, 0);
        tbl[11] = mk(1, 2'b00, 0, 1, 2'd1,  0, 2'd1, 2'b00, 2'b10, 1, 0);
        tbl[12] = mk(1, 2'b01, 0, 0, 2'd0,  0, 2'd1, 2'b00, 2'b00, 1, 0);
        tbl[13] = mk(1, 2'b01, 1, 1, 2'd0,  1, 2'd0, 2'b01, 2'b01, 1, 0);
        tbl[14] = mk(1, 2'b00, 0, 1, 2'd3,  0, 2'd0, 2'b00, 2'b00, 1, 0);
        tbl[15] = mk(1, 2'b00, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 1);
        tbl[16] = mk(1, 2'b01, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 1);
        tbl[17] = mk(0, 2'b01, 0, 1, 2'd0,  1, 2'd0, 2'b00, 2'b00, 1, 1);
        tbl[18] = mk(1, 2'b11, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 0, 0);
        tbl[19] = mk(1, 2'b11, 1, 0, 2'd0,  1, 2'd0, 2'b01, 2'b00, 1, 0);
        tbl[20] = mk(1, 2'b00, 0, 1, 2'd1,  0, 2'd0, 2'b00, 2'b10, 1, 0);
        tbl[21] = mk(1, 2'b00, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 1, 1);
        tbl[22] = mk(1, 2'b00, 0, 1, 2'd0,  0, 2'd0, 2'b00, 2'b01, 1, 1);
        tbl[23] = mk(1, 2'b00, 0, 0, 2'd0,  0, 2'd0, 2'b00, 2'b00, 0, 1);

        @(posedge clk_i);
        #1;
        model_reset();

        for (int i = 0; i < NVEC; i++) begin
            rstn_i = tbl[i].rstn; req_val_i = tbl[i].val; l15_ack_i = tbl[i].ack;
            l15_rtrn_val_i = tbl[i].rv; l15_rtrn_threadid_i = tbl[i].tid;
            sample();
            chk("tbl_l15_val",  128'(l15_val_o),      128'(tbl[i].e_val));
            chk("tbl_threadid", 128'(l15_threadid_o), 128'(tbl[i].e_tid));
            chk("tbl_req_ack",  128'(req_ack_o),      128'(tbl[i].e_ack));
            chk("tbl_rtrn_val", 128'(rtrn_val_o),     128'(tbl[i].e_rtrn));
            chk("tbl_busy",     128'(busy_o),         128'(tbl[i].e_busy));
            chk("tbl_err",      128'(err_o),          128'(tbl[i].e_err));
            if (i == 1) chk("tbl_addr_req0", 128'(l15_addr_o), 128'(ADDR0));
            if (i == 6) chk("tbl_addr_req1", 128'(l15_addr_o), 128'(ADDR1));
            advance();
        end

        // Outstanding limit: requester 0 saturates, requester 1 keeps winning.
        rstn_i = 1'b0; req_val_i = '0; l15_ack_i = 1'b0; l15_rtrn_val_i = 1'b0;
        sample(); advance();
        rstn_i = 1'b1; req_val_i = 2'b01; l15_ack_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample(); advance();
        end
        req_val_i = 2'b11;
        ack1_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            chk("max_no_ack0", 128'(req_ack_o[0]), 128'(0));
            if (req_ack_o[1]) ack1_cnt++;
            advance();
        end
        chk("max_ack1_count", 128'(ack1_cnt), 128'(4));
        req_val_i = 2'b01; l15_ack_i = 1'b0;
        l15_rtrn_val_i = 1'b1; l15_rtrn_threadid_i = 2'd0;
        sample();
        chk("max_still_blocked", 128'(l15_val_o), 128'(0));
        advance();
        l15_rtrn_val_i = 1'b0;
        sample(); advance();
        sample();
        chk("max_regrant_val", 128'(l15_val_o),      128'(1));
        chk("max_regrant_tid", 128'(l15_threadid_o), 128'(0));
        advance();

        // Randomized traffic, mostly well-formed returns with occasional errors.
        for (int c = 0; c < 3000; c++) begin
            rstn_i       = ($urandom_range(0, 299) != 0);
            req_val_i    = NUM_REQ'($urandom);
            req_rqtype_i = (NUM_REQ*5)'($urandom);
            req_size_i   = (NUM_REQ*3)'($urandom);
            req_addr_i   = (NUM_REQ*ADDR_W)'({$urandom, $urandom, $urandom});
            req_data_i   = (NUM_REQ*DATA_W)'({$urandom, $urandom, $urandom, $urandom});
            l15_ack_i    = ($urandom_range(0, 2) != 0);
            l15_rtrn_data_i = {$urandom, $urandom};
            tsel = int'($urandom_range(0, NUM_REQ-1));
            if ($urandom_range(0, 99) == 0) begin
                l15_rtrn_val_i      = 1'b1;
                l15_rtrn_threadid_i = TID_W'($urandom_range(NUM_REQ, 3));
            end else begin
                l15_rtrn_threadid_i = TID_W'(tsel);
                l15_rtrn_val_i      = ($urandom_range(0, 1) == 1) &&
                                      (m_cnt[tsel] > 0 || $urandom_range(0, 49) == 0);
            end
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
